// File: rtl/sobel_mag.sv
// Sobel gradient magnitude stage: |Gx|+|Gy| saturated to 8 bits, raster-tagged, into a FWFT FIFO.
// Optional binary edge map via SOBEL_THRESH_EN (adds parameter THRESH).
module sobel_mag #(
  parameter int N          = 5,
  parameter int M          = 5,
  parameter int K          = 3,
`ifdef SOBEL_THRESH_EN
  parameter logic [7:0] THRESH = 8'd128,
`endif
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] gx_in,
  input  logic [15:0] gy_in,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic [7:0]  pxl_out,
  output logic        out_valid,
  output logic        out_eol,
  output logic        out_eof,
  output logic        overflow
);

  localparam int COL_LAST = N - K;
  localparam int ROW_LAST = M - K;
  localparam int CW = (COL_LAST > 0) ? $clog2(COL_LAST + 1) : 1;
  localparam int RW = (ROW_LAST > 0) ? $clog2(ROW_LAST + 1) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_ONE = 1;
  localparam logic [RW-1:0] ROW_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  // Absolute value; the most negative code saturates so the result fits 15 bits.
  function automatic logic [15:0] sat_abs(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'h8000) r = 16'h7fff;
    else if (v[15])    r = ~v + 16'd1;
    else               r = v;
    return r;
  endfunction

  logic [15:0]   abs_gx_r, abs_gy_r;
  logic          s1_valid_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [9:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          overflow_r;

  logic [16:0]   sum_s;
  logic [7:0]    mag_s, pxl_s;
  logic          eol_s, eof_s, full_s, rd_en_s, wr_en_s;

  // Stage 1: register absolute values alongside the input valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      abs_gx_r   <= 16'd0;
      abs_gy_r   <= 16'd0;
    end else begin
      s1_valid_r <= in_valid;
      abs_gx_r   <= sat_abs(gx_in);
      abs_gy_r   <= sat_abs(gy_in);
    end
  end

  // Stage 2 datapath, raster tags and FIFO handshake decisions.
  always_comb begin
    sum_s = {1'b0, abs_gx_r} + {1'b0, abs_gy_r};
    if (sum_s > 17'd255) mag_s = 8'd255;
    else                 mag_s = sum_s[7:0];
`ifdef SOBEL_THRESH_EN
    if (mag_s >= THRESH) pxl_s = 8'd255;
    else                 pxl_s = 8'd0;
`else
    pxl_s = mag_s;
`endif
    eol_s   = (col_r == COL_LAST[CW-1:0]);
    eof_s   = eol_s && (row_r == ROW_LAST[RW-1:0]);
    full_s  = (count_r == FIFO_DEPTH[AW:0]);
    rd_en_s = (count_r != {(AW+1){1'b0}}) && out_ready;
    wr_en_s = s1_valid_r && (!full_s || rd_en_s);
  end

  // Raster counters advance on every stage-2 result, dropped or not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (s1_valid_r) begin
      if (eol_s) begin
        col_r <= {CW{1'b0}};
        if (eof_s) row_r <= {RW{1'b0}};
        else       row_r <= row_r + ROW_ONE;
      end else begin
        col_r <= col_r + COL_ONE;
      end
    end
  end

  // Output FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 10'd0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {eof_s, eol_s, pxl_s};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (s1_valid_r && !wr_en_s) overflow_r <= 1'b1;
    end
  end

  assign out_valid                  = (count_r != {(AW+1){1'b0}});
  assign {out_eof, out_eol, pxl_out} = mem_r[rd_ptr_r];
  assign overflow                   = overflow_r;

endmodule

// File: tb/tb_sobel_mag.sv
// Scoreboard bench for sobel_mag: magnitude, saturation, raster tags, backpressure, async reset.
module tb_sobel_mag;

  localparam int N = 5;
  localparam int M = 5;
  localparam int K = 3;
`ifdef SOBEL_THRESH_EN
  localparam int THRESH = 10;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] gx_in, gy_in;
  logic        in_valid, out_ready;
  logic [7:0]  pxl_out;
  logic        out_valid, out_eol, out_eof, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int mcol     = 0;
  int mrow     = 0;
  logic [9:0] exp_q[$];

  sobel_mag #(
    .N(N), .M(M), .K(K),
`ifdef SOBEL_THRESH_EN
    .THRESH(8'd10),
`endif
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .gx_in(gx_in), .gy_in(gy_in), .in_valid(in_valid),
    .out_ready(out_ready), .pxl_out(pxl_out), .out_valid(out_valid),
    .out_eol(out_eol), .out_eof(out_eof), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_pix(input int gx, input int gy);
    logic signed [15:0] sx, sy;
    int ax, ay, s;
    sx = gx[15:0];
    sy = gy[15:0];
    ax = (sx < 0) ? -int'(sx) : int'(sx);
    ay = (sy < 0) ? -int'(sy) : int'(sy);
    if (ax > 32767) ax = 32767;
    if (ay > 32767) ay = 32767;
    s = ax + ay;
    if (s > 255) s = 255;
`ifdef SOBEL_THRESH_EN
    return (s >= THRESH) ? 8'd255 : 8'd0;
`else
    return s[7:0];
`endif
  endfunction

  // One input beat; tags always advance, the expected entry is queued only if it will be stored.
  task automatic drive(input int gx, input int gy, input bit push);
    logic eol, eof;
    eol = (mcol == N - K);
    eof = eol && (mrow == M - K);
    if (push) exp_q.push_back({eof, eol, model_pix(gx, gy)});
    if (eol) begin
      mcol = 0;
      mrow = eof ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
    gx_in    = gx[15:0];
    gy_in    = gy[15:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Assert reset between edges and check the outputs clear without a clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    exp_q.delete();
    mcol = 0;
    mrow = 0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_eol", out_eol, 0);
    check("rst_eof", out_eof, 0);
    check("rst_pxl", pxl_out, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Pop and compare every entry the DUT hands over.
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pxl", pxl_out, e[7:0]);
        check("eol", out_eol, e[8]);
        check("eof", out_eof, e[9]);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    gx_in     = 16'd0;
    gy_in     = 16'd0;
    @(posedge clk); #1;
    do_reset();

    // Magnitude and latency
    drive(3, -4, 1);
    check("lat_t1", out_valid, 0);
    idle();
    check("lat_t2", out_valid, 1);
    idle();
    check("lat_t3", out_valid, 0);

    // Saturation
    drive(200, 100, 1);
    drive(-32768, 0, 1);
    drive(0, 0, 1);
    drive(-32768, -32768, 1);
    drive(32767, 1, 1);
`ifdef SOBEL_THRESH_EN
    drive(6, 4, 1);
    drive(5, 4, 1);
`endif
    drain("drain_sat");

    // Random pixels, back to back
    for (int i = 0; i < 8; i++) drive(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1);
    for (int i = 0; i < 6; i++) drive(int'($urandom_range(0, 300)) - 150, int'($urandom_range(0, 300)) - 150, 1);
    drain("drain_rand");
    check("ovf_clean", overflow, 0);

    // Raster tags over one frame plus one
    do_reset();
    for (int i = 1; i <= 10; i++) drive(i, i, 1);
    drain("drain_raster");

    // Backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) drive(i, 0, i <= 4);
    idle();
    idle();
    check("ovf_set", overflow, 1);
    check("full_valid", out_valid, 1);
    out_ready = 1'b1;
    drain("drain_ovf");
    idle();
    check("ovf_empty", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Simultaneous read and write while full
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) drive(i * 3, i, 1);
    out_ready = 1'b1;
    for (int i = 6; i <= 12; i++) drive(i * 3, i, 1);
    drain("drain_simul");
    check("simul_ovf", overflow, 0);

    // Async reset mid-frame
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) drive(i, 1, 0);
    idle();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_ovf", overflow, 1);
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) drive(i * 7, -i, 1);
    drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
